unified_mem_arbiter: RTL and testbench

Arbitrates one single-port unified memory between the fetch stage (instruction reads) and the load/store unit (data reads/writes) of the 5-stage core. Each access is sequenced as a request/acknowledge transaction against a variable-latency memory. Loads and stores have priority over fetches, and a streak limit prevents fetch starvation. The pipeline's Stall logic uses the per-port pending status.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/unified_mem_arbiter_if.sv | 52 +++++
 rtl/mem_arb_prio.sv | 28 ++
 rtl/unified_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IF   = 2'd1,
    G_LS   = 2'd2
  } grant_t;

  localparam logic [3:0] FETCH_MASK = 4'hF;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch, load/store and memory signal bundle
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_kill;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_wr;
  logic [3:0]    ls_mask;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_ack;
  logic [DW-1:0] ls_rdata;

  logic          mem_cs;
  logic          mem_wr;
  logic [3:0]    mem_mask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          busy;
  logic          err;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_ack, if_rdata,
    input  ls_req, ls_wr, ls_mask, ls_addr, ls_wdata,
    output ls_ack, ls_rdata,
    output mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy, err
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_ack, if_rdata,
    output ls_req, ls_wr, ls_mask, ls_addr, ls_wdata,
    input  ls_ack, ls_rdata,
    input  mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy, err
  );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - combinational winner select between fetch and load/store
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic   i_if_req,
  input  logic   i_if_kill,
  input  logic   i_ls_req,
  input  logic   i_streak_max,
  output grant_t o_grant
);

  logic w_if_ok;

  assign w_if_ok = i_if_req && !i_if_kill;

  // A waiting fetch overrides the LSU only once the LSU has used up its streak.
  always_comb begin
    o_grant = G_NONE;
    if (w_if_ok && i_streak_max) begin
      o_grant = G_IF;
    end else if (i_ls_req) begin
      o_grant = G_LS;
    end else if (w_if_ok) begin
      o_grant = G_IF;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port memory arbiter for fetch and load/store traffic
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  grant_t        r_grant;
  grant_t        w_grant;
  logic [SW-1:0] r_streak;
  logic [WW-1:0] r_wait;
  logic          r_kill;
  logic          r_err;
  logic [DW-1:0] r_rdata;
  logic          r_mem_cs;
  logic          r_mem_wr;
  logic [3:0]    r_mem_mask;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          w_streak_max;
  logic          w_timeout;
  logic          w_if_ack;
  logic          w_ls_ack;

  assign w_streak_max = (r_streak == SW'(MAX_LS_STREAK));
  assign w_timeout    = (r_wait == WW'(TIMEOUT));

  mem_arb_prio u_prio (
    .i_if_req     (bus.if_req),
    .i_if_kill    (bus.if_kill),
    .i_ls_req     (bus.ls_req),
    .i_streak_max (w_streak_max),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A kill arriving in the response cycle itself must still swallow the ack.
  always_comb begin
    w_state_nxt = r_state;
    w_if_ack    = 1'b0;
    w_ls_ack    = 1'b0;
    case (r_state)
      IDLE: if (w_grant != G_NONE) w_state_nxt = BUSY;
      BUSY: if (bus.mem_ready || w_timeout) w_state_nxt = RESP;
      RESP: begin
        w_state_nxt = IDLE;
        w_if_ack    = (r_grant == G_IF) && !r_kill && !bus.if_kill;
        w_ls_ack    = (r_grant == G_LS);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant     <= G_NONE;
      r_streak    <= '0;
      r_wait      <= '0;
      r_kill      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_mask  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (w_grant == G_IF || !bus.if_req) begin
            r_streak <= '0;
          end else if (w_grant == G_LS && !w_streak_max) begin
            r_streak <= r_streak + SW'(1);
          end
          if (w_grant == G_LS) begin
            r_grant     <= G_LS;
            r_mem_cs    <= 1'b1;
            r_mem_wr    <= bus.ls_wr;
            r_mem_mask  <= bus.ls_mask;
            r_mem_addr  <= bus.ls_addr;
            r_mem_wdata <= bus.ls_wdata;
            r_wait      <= WW'(1);
          end else if (w_grant == G_IF) begin
            r_grant     <= G_IF;
            r_mem_cs    <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_mask  <= FETCH_MASK;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_wait      <= WW'(1);
          end
        end
        BUSY: begin
          if (r_grant == G_IF && bus.if_kill) r_kill <= 1'b1;
          if (bus.mem_ready) begin
            r_rdata  <= r_mem_wr ? '0 : bus.mem_rdata;
            r_mem_cs <= 1'b0;
          end else if (w_timeout) begin
            r_rdata  <= '0;
            r_err    <= 1'b1;
            r_mem_cs <= 1'b0;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        RESP: begin
          r_grant <= G_NONE;
          r_rdata <= '0;
        end
        default: r_grant <= G_NONE;
      endcase
    end
  end

  assign bus.if_ack    = w_if_ack;
  assign bus.ls_ack    = w_ls_ack;
  assign bus.if_rdata  = w_if_ack ? r_rdata : '0;
  assign bus.ls_rdata  = w_ls_ack ? r_rdata : '0;
  assign bus.mem_cs    = r_mem_cs;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_mask  = r_mem_mask;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed and randomized checks of the unified memory arbiter
module tb_unified_mem_arbiter;

  localparam int TB_MAXS    = 4;
  localparam int TB_TIMEOUT = 16;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_fail;
  int   n_checks;
  int   lat;
  int   mem_cnt;

  logic [31:0] phy_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  unified_mem_arbiter #(
    .AW(32), .DW(32), .MAX_LS_STREAK(TB_MAXS), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endfunction

  // Memory answers lat cycles after mem_cs rises; lat < 0 never answers.
  always @(negedge clk) begin
    logic [31:0] old;
    logic [31:0] bm;
    if (!bus.mem_cs) begin
      mem_cnt = 0;
      bus.mem_ready = 1'b0;
    end else begin
      if (lat >= 0 && mem_cnt == lat) begin
        bus.mem_ready = 1'b1;
        old = phy_mem.exists(bus.mem_addr) ? phy_mem[bus.mem_addr] : init_word(bus.mem_addr);
        if (bus.mem_wr) begin
          bm = {{8{bus.mem_mask[3]}}, {8{bus.mem_mask[2]}}, {8{bus.mem_mask[1]}}, {8{bus.mem_mask[0]}}};
          phy_mem[bus.mem_addr] = (old & ~bm) | (bus.mem_wdata & bm);
          bus.mem_rdata = $urandom;
        end else begin
          bus.mem_rdata = old;
        end
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      mem_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input bit is_ls, input bit wr, input logic [3:0] mask, input logic [31:0] addr,
                      input logic [31:0] wdata, input int lat_i, input string tag);
    int          c;
    int          cs_cnt;
    bit          ok;
    bit          got;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_mask;
    lat = lat_i;
    @(posedge clk); #1;
    if (is_ls) begin
      bus.ls_req = 1'b1; bus.ls_wr = wr; bus.ls_mask = mask;
      bus.ls_addr = addr; bus.ls_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    exp_mask = is_ls ? mask : 4'hF;
    c = 0; cs_cnt = 0; ok = 1'b1; got = 1'b0; rd = '0;
    while (!got && c < 64) begin
      @(negedge clk);
      if (bus.mem_cs) begin
        cs_cnt++;
        if (bus.mem_addr !== addr || bus.mem_wr !== (is_ls & wr) || bus.mem_mask !== exp_mask) ok = 1'b0;
        if (is_ls && wr && bus.mem_wdata !== wdata) ok = 1'b0;
      end
      if (is_ls ? bus.if_ack : bus.ls_ack) ok = 1'b0;
      if (is_ls ? bus.ls_ack : bus.if_ack) begin
        got = 1'b1;
        rd = is_ls ? bus.ls_rdata : bus.if_rdata;
      end else begin
        c++;
      end
    end
    if (lat_i < 0 || (is_ls && wr)) exp_rd = '0;
    else exp_rd = ref_read(addr);
    if (lat_i >= 0 && is_ls && wr) ref_write(addr, wdata, mask);
    chk({tag, "_acked"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(c), (lat_i < 0) ? 64'(TB_TIMEOUT + 1) : 64'(lat_i + 2));
    chk({tag, "_cs_cycles"}, 64'(cs_cnt), (lat_i < 0) ? 64'(TB_TIMEOUT) : 64'(lat_i + 1));
    chk({tag, "_fields"}, 64'(ok), 64'd1);
    chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after"}, 64'({bus.busy, bus.if_ack, bus.ls_ack}), 64'd0);
  endtask

  initial begin
    int exp_g;
    int got_g;
    int since_if;
    int nack;
    int collide;
    int seen;
    int k;
    n_pass = 0; n_fail = 0; n_checks = 0; lat = 0; mem_cnt = 0;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
    bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_mask = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    phy_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({bus.if_ack, bus.ls_ack, bus.mem_cs, bus.mem_wr, bus.busy, bus.err}), 64'd0);
    chk("rst_mem_bus", 64'({bus.mem_mask, bus.mem_addr}), 64'd0);
    chk("rst_rdata", 64'({bus.if_rdata, bus.ls_rdata}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'({bus.busy, bus.mem_cs, bus.err}), 64'd0);

    xact(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 2, "load_100");
    xact(1'b1, 1'b1, 4'b0011, 32'h40, 32'h1234, 1, "store_40");
    xact(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 0, "reload_40");
    xact(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 0, "fetch_100");

    // Both ports request back-to-back with a zero-wait memory.
    lat = 0;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_mask = 4'hF; bus.ls_addr = 32'h300;
    since_if = 0; nack = 0; collide = 0;
    for (int cyc = 0; cyc < 300 && nack < 10; cyc++) begin
      @(negedge clk);
      if (bus.if_ack && bus.ls_ack) collide++;
      if (bus.if_ack || bus.ls_ack) begin
        got_g = bus.if_ack ? 1 : 2;
        exp_g = (since_if == TB_MAXS) ? 1 : 2;
        chk($sformatf("contend_grant%0d", nack), 64'(got_g), 64'(exp_g));
        since_if = (exp_g == 1) ? 0 : since_if + 1;
        nack++;
      end
    end
    chk("contend_acks", 64'(nack), 64'd10);
    chk("contend_collide", 64'(collide), 64'd0);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);
    chk("contend_idle", 64'(bus.busy), 64'd0);

    // Kill during a fetch in BUSY: access completes but no if_ack.
    lat = 2;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.if_kill = 1'b1;
    @(posedge clk); #1;
    bus.if_kill = 1'b0; bus.if_req = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.if_ack || bus.ls_ack) seen++;
    end
    chk("kill_busy_no_ack", 64'(seen), 64'd0);
    chk("kill_busy_idle", 64'({bus.busy, bus.mem_cs}), 64'd0);

    // Kill seen with the request in IDLE: never granted.
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_kill = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy || bus.mem_cs) seen++;
    end
    chk("kill_idle_no_grant", 64'(seen), 64'd0);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_kill = 1'b0;
    xact(1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 1, "after_kill_load");
    xact(1'b0, 1'b0, 4'hF, 32'h48, 32'h0, 1, "after_kill_fetch");

    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 2));
      xact(k != 0, k == 2, 4'($urandom_range(1, 15)), 32'($urandom_range(0, 7)) << 2,
           $urandom, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    chk("err_before_timeout", 64'(bus.err), 64'd0);
    xact(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, -1, "timeout_load");
    chk("err_after_timeout", 64'(bus.err), 64'd1);
    xact(1'b1, 1'b0, 4'hF, 32'h24, 32'h0, 0, "good_after_timeout");
    chk("err_sticky", 64'(bus.err), 64'd1);

    // Asynchronous reset in the middle of a fetch's BUSY phase.
    lat = -1;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_outputs", 64'({bus.mem_cs, bus.busy, bus.if_ack, bus.ls_ack, bus.err}), 64'd0);
    @(negedge clk);
    bus.if_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_no_ack", 64'({bus.busy, bus.if_ack, bus.ls_ack}), 64'd0);
    xact(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1, "fetch_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
